// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage with a 2-entry skid, load-use bubble and flush.
// Define PIPE_STATS_EN to build the saturating stall/bubble counters; otherwise they read 0.
module pipe_stage_buffer #(
    parameter int unsigned DATA_W = 146,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble_req,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  r_skid;
    logic [DATA_W-1:0]  w_next_main;
    logic [DATA_W-1:0]  w_next_skid;
    logic               w_accept;
    logic               w_drain;

    // in_ready depends only on held state and local controls, never on out_ready
    assign in_ready  = reset & (r_state != FULL) & ~bubble_req & ~flush;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_main  = r_main;
        w_next_skid  = r_skid;
        if (flush) begin
            w_next_state = EMPTY;
            w_next_main  = '0;
            w_next_skid  = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ONE;
                        w_next_main  = in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_next_main = in_data;
                    end else if (w_accept) begin
                        w_next_state = FULL;
                        w_next_skid  = in_data;
                    end else if (w_drain) begin
                        w_next_state = EMPTY;
                        w_next_main  = '0;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_next_state = ONE;
                        w_next_main  = r_skid;
                        w_next_skid  = '0;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                    w_next_main  = '0;
                    w_next_skid  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next_state;
            r_main  <= w_next_main;
            r_skid  <= w_next_skid;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Both counters saturate at all-ones instead of wrapping
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bubble_req && !flush && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: directed scenarios followed by random traffic.
// Expected payload order comes from a 2-deep queue model; counters from plain event counting.
module tb_pipe_stage_buffer;

    localparam int unsigned DATA_W = 146;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              bubble_req;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bubble_req (bubble_req),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [DATA_W-1:0] sb[$];
    int unsigned       m_stall  = 0;
    int unsigned       m_bubble = 0;
    bit                chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle, compare against model, then advance model for the coming edge
    always @(negedge clock) begin
        logic              exp_rdy;
        logic              exp_val;
        logic [DATA_W-1:0] exp_data;
        exp_rdy  = reset && (sb.size() < 2) && !bubble_req && !flush;
        exp_val  = (sb.size() > 0);
        exp_data = exp_val ? sb[0] : '0;
        if (chk_en) begin
            chk("in_ready",  DATA_W'(in_ready),  DATA_W'(exp_rdy));
            chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_val));
            chk("out_data",  out_data, exp_data);
`ifdef PIPE_STATS_EN
            chk("stall_cnt",  DATA_W'(stall_cnt),  DATA_W'(m_stall));
            chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bubble));
`else
            chk("stall_cnt",  DATA_W'(stall_cnt),  '0);
            chk("bubble_cnt", DATA_W'(bubble_cnt), '0);
`endif
        end
        if (!reset) begin
            sb.delete();
            m_stall  = 0;
            m_bubble = 0;
            chk_en   = 1'b1;
        end else begin
            if (in_valid && !exp_rdy && m_stall < CNT_MAX) m_stall++;
            if (bubble_req && !flush && m_bubble < CNT_MAX) m_bubble++;
            if (exp_val && out_ready) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (in_valid && exp_rdy) sb.push_back(in_data);
        end
    end

    task automatic cyc(input logic rst, input logic v, input logic [DATA_W-1:0] d,
                       input logic bub, input logic fl, input logic ordy);
        reset      = rst;
        in_valid   = v;
        in_data    = d;
        bubble_req = bub;
        flush      = fl;
        out_ready  = ordy;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < 5; i++) d = {d[DATA_W-33:0], 32'($urandom)};
        return d;
    endfunction

    localparam logic [DATA_W-1:0] A = 146'h1A;
    localparam logic [DATA_W-1:0] B = 146'h2B;
    localparam logic [DATA_W-1:0] C = 146'h3C;
    localparam logic [DATA_W-1:0] D = 146'h4D;
    localparam logic [DATA_W-1:0] E = 146'h5E;
    localparam logic [DATA_W-1:0] F = 146'h6F;

    initial begin
        // 1: stream
        cyc(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 1, DATA_W'(i), 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        // 2: backpressure, then extra stalled cycles with C waiting
        cyc(1, 1, A, 0, 0, 0);
        cyc(1, 1, B, 0, 0, 0);
        cyc(1, 1, C, 0, 0, 0);
        cyc(1, 1, C, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        // 3: bubble for one cycle with C offered
        cyc(1, 1, C, 1, 0, 1);
        cyc(1, 1, C, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        // 4: flush with stage full and F offered, also combined with bubble
        cyc(1, 1, D, 0, 0, 0);
        cyc(1, 1, E, 0, 0, 0);
        cyc(1, 1, F, 1, 1, 0);
        cyc(1, 1, F, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        // 5: reset mid-operation
        cyc(1, 1, A, 0, 0, 0);
        cyc(1, 1, B, 0, 0, 0);
        cyc(0, 1, C, 0, 0, 0);
        cyc(1, 1, D, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        // 6: counter saturation (stall and bubble)
        cyc(0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 1, DATA_W'(100 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, E, 1, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) >= 2) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                rnd_data(),
                ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 5)  ? 1'b1 : 1'b0,
                ($urandom_range(99) < 60) ? 1'b1 : 1'b0);
        end
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
